// File: rtl/sign_apply_pkg.sv
// rtl/sign_apply_pkg.sv - shared types and sizing helpers for the serial sign-apply block
//
// Purpose : FSM state encoding and elaboration-time sizing functions used by
//           sign_apply_serial and its digit slice.
// Contents: state_e   - IDLE / BUSY / DONE
//           nbeats()  - number of DIGIT-wide beats needed to cover WIDTH bits
//           beat_w()  - width of the beat counter, clog2(nbeats)+1
package sign_apply_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nbeats(input int width, input int digit);
    return width / digit;
  endfunction

  // One spare bit so the counter can represent NBEATS itself, not just NBEATS-1.
  function automatic int beat_w(input int width, input int digit);
    return $clog2(width / digit) + 1;
  endfunction

endpackage

// File: rtl/sign_apply_digit.sv
// rtl/sign_apply_digit.sv - combinational DIGIT-bit conditional-invert-and-add slice
//
// Purpose : One beat of the serial negate. The slice is inverted when neg is set
//           and the incoming ripple carry is added, producing DIGIT result bits
//           and the carry for the next beat.
// Ports   : slice [DIGIT-1:0] in  - next DIGIT magnitude bits, LSB-first
//           neg               in  - 1 = negate (invert slice)
//           cin               in  - ripple carry from the previous beat
//           r     [DIGIT-1:0] out - result bits for this beat
//           cout              out - carry into the next beat
module sign_apply_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] slice,
  input  logic             neg,
  input  logic             cin,
  output logic [DIGIT-1:0] r,
  output logic             cout
);

  logic [DIGIT-1:0] inv;
  logic [DIGIT:0]   sum;

  assign inv  = slice ^ {DIGIT{neg}};
  assign sum  = {1'b0, inv} + {{DIGIT{1'b0}}, cin};
  assign r    = sum[DIGIT-1:0];
  assign cout = sum[DIGIT];

endmodule

// File: rtl/sign_apply_serial.sv
// rtl/sign_apply_serial.sv - bit-serial magnitude+sign to two's-complement converter
//
// Purpose : Rebuilds a WIDTH-bit two's-complement word from an unsigned
//           magnitude and a sign flag, DIGIT bits per cycle, LSB-first, with a
//           single carry flop. Flags results that do not fit in WIDTH signed bits.
// Config  : SIGN_APPLY_SAT_EN - when defined, overflowing results are clamped to
//           the most negative / most positive value at the BUSY->DONE edge.
// Ports   : clk                   in  - rising-edge clock
//           rst_n                 in  - synchronous active-low reset
//           in_valid / in_ready       - input handshake (ready only in IDLE)
//           in_mag [WIDTH-1:0]    in  - unsigned magnitude
//           in_neg                in  - 1 = result is -in_mag
//           out_valid / out_ready     - output handshake (valid only in DONE)
//           out_data [WIDTH-1:0]  out - two's-complement result
//           out_ovf               out - result not representable in WIDTH bits
module sign_apply_serial
  import sign_apply_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mag,
  input  logic             in_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int NBEATS = nbeats(WIDTH, DIGIT);
  localparam int BEAT_W = beat_w(WIDTH, DIGIT);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_DONE = DONE;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

`ifdef SIGN_APPLY_SAT_EN
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
`endif

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("sign_apply_serial: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  mag_q,   mag_d;
  logic [WIDTH-1:0]  data_q,  data_d;
  logic              neg_q,   neg_d;
  logic              carry_q, carry_d;
  logic              ovf_q,   ovf_d;
  logic [BEAT_W-1:0] beat_q,  beat_d;

  logic [DIGIT-1:0]  dig_r;
  logic              dig_cout;
  logic [WIDTH-1:0]  data_sh;
  logic              ovf_in;

  sign_apply_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .slice (mag_q[DIGIT-1:0]),
    .neg   (neg_q),
    .cin   (carry_q),
    .r     (dig_r),
    .cout  (dig_cout)
  );

  // New result bits enter at the MSB end; after NBEATS beats the first beat's
  // bits have walked down to the LSB position.
  generate
    if (NBEATS == 1) begin : g_sh_single
      assign data_sh = dig_r;
    end else begin : g_sh_multi
      assign data_sh = {dig_r, data_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  // -2^(WIDTH-1) is representable, so a negated magnitude only overflows when
  // the MSB is set and any lower bit is also set.
  assign ovf_in = in_mag[WIDTH-1] & (~in_neg | (|in_mag[WIDTH-2:0]));

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    data_d  = data_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_BUSY;
          mag_d   = in_mag;
          neg_d   = in_neg;
          carry_d = in_neg;  // the +1 of ~x+1 enters as the first carry-in
          beat_d  = '0;
          ovf_d   = ovf_in;
        end
      end
      ST_BUSY: begin
        mag_d   = mag_q >> DIGIT;
        data_d  = data_sh;
        carry_d = dig_cout;
        beat_d  = beat_q + BEAT_W'(1);
        if (beat_q == LAST_BEAT) begin
          state_d = ST_DONE;
`ifdef SIGN_APPLY_SAT_EN
          if (ovf_q) begin
            data_d = neg_q ? SAT_NEG : SAT_POS;
          end
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mag_q   <= '0;
      data_q  <= '0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      data_q  <= data_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      beat_q  <= beat_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = data_q;
  assign out_ovf   = ovf_q;

endmodule
